// File: rtl/fp_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_issue_pkg
// Purpose  : Shared op codes, FSM encoding, constants and flag indices.
// Revision : 1.0 - initial release
// ============================================================================
package fp_issue_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [4:0] FLAGS_INVALID = 5'b1 << FLAG_NV;

endpackage
`default_nettype wire

// File: rtl/fp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_issue_ctrl
// Purpose  : Issues one FP operation at a time to an external core, tracks
//            timeout/flush, and returns the result through a wb handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fp_issue_ctrl
    import fp_issue_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        fp_start,
    output logic [2:0]  fp_op,
    output logic [31:0] fp_a,
    output logic [31:0] fp_b,
    input  logic [31:0] fp_result,
    input  logic [4:0]  fp_flags,
    input  logic        fp_valid,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic [4:0]  wb_flags,
    output logic [4:0]  fflags,
    input  logic        fflags_clr,
    output logic        busy,
    output logic        timeout_err
);

    logic [2:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      data_q, data_d;
    logic [4:0]       flg_q, flg_d;
    logic [4:0]       fflags_q, fflags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_cnt_hit;
    logic             w_wb_fire;

    assign w_cnt_inc = cnt_q + CNT_W'(1);
    assign w_cnt_hit = (w_cnt_inc >= CNT_W'(TIMEOUT));
    assign w_wb_fire = (state_q == ST_RESP) && wb_ready && !flush;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        data_d  = data_q;
        flg_d   = flg_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    rd_d = req_rd;
                    // Unsupported op codes never reach the core
                    if (req_op[2]) begin
                        data_d  = 32'h0;
                        flg_d   = FLAGS_INVALID;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (fp_valid) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        data_d  = fp_result;
                        flg_d   = fp_flags;
                        state_d = ST_RESP;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = w_cnt_inc;
                if (fp_valid) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        data_d  = fp_result;
                        flg_d   = fp_flags;
                        state_d = ST_RESP;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end else if (w_cnt_hit) begin
                    data_d  = QNAN;
                    flg_d   = FLAGS_INVALID;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_DRAIN: begin
                cnt_d = w_cnt_inc;
                if (fp_valid || w_cnt_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (flush || wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A clear that coincides with a handshake leaves only the new flags
    always_comb begin
        fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (w_wb_fire ? flg_q : 5'b0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            rd_q     <= 5'b0;
            data_q   <= 32'h0;
            flg_q    <= 5'b0;
            fflags_q <= 5'b0;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            flg_q    <= flg_d;
            fflags_q <= fflags_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign fp_start    = (state_q == ST_ISSUE);
    assign fp_op       = op_q;
    assign fp_a        = a_q;
    assign fp_b        = b_q;
    assign wb_valid    = (state_q == ST_RESP);
    assign wb_data     = data_q;
    assign wb_rd       = rd_q;
    assign wb_flags    = flg_q;
    assign fflags      = fflags_q;
    assign timeout_err = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_issue_ctrl
// Purpose  : Directed self-checking bench for fp_issue_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic        fp_start;
    logic [2:0]  fp_op;
    logic [31:0] fp_a, fp_b, fp_result;
    logic [4:0]  fp_flags;
    logic        fp_valid;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd, wb_flags, fflags;
    logic        fflags_clr, busy, timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;

    fp_issue_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
        .fp_start(fp_start), .fp_op(fp_op), .fp_a(fp_a), .fp_b(fp_b),
        .fp_result(fp_result), .fp_flags(fp_flags), .fp_valid(fp_valid),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_flags(wb_flags), .fflags(fflags),
        .fflags_clr(fflags_clr), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fp_start === 1'b1) n_starts++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = 3'b0; req_a = 32'h0; req_b = 32'h0;
        req_rd = 5'd0; flush = 1'b0; fp_result = 32'h0; fp_flags = 5'b0;
        fp_valid = 1'b0; wb_ready = 1'b0; fflags_clr = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_fp_start", 32'(fp_start), 32'h0);
        chk("rst_fflags", 32'(fflags), 32'h0);
        step();
        rst = 1'b1;
        step();
        chk("rst_req_ready", 32'(req_ready), 32'h1);

        // add, core latency 3
        send(3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd5);
        chk("add_fp_start", 32'(fp_start), 32'h1);
        chk("add_fp_a", fp_a, 32'h3F80_0000);
        chk("add_fp_b", fp_b, 32'h4000_0000);
        chk("add_req_ready", 32'(req_ready), 32'h0);
        step();
        chk("add_start_once", 32'(fp_start), 32'h0);
        step();
        step();
        chk("add_wb_early", 32'(wb_valid), 32'h0);
        fp_valid = 1'b1; fp_result = 32'h4040_0000; fp_flags = 5'b0;
        step();
        fp_valid = 1'b0;
        chk("add_wb_valid", 32'(wb_valid), 32'h1);
        chk("add_wb_data", wb_data, 32'h4040_0000);
        chk("add_wb_flags", 32'(wb_flags), 32'h0);
        chk("add_wb_rd", 32'(wb_rd), 32'd5);
        chk("add_n_starts", 32'(n_starts), 32'd1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("add_idle", 32'(req_ready), 32'h1);
        chk("add_fflags", 32'(fflags), 32'h0);

        // illegal op goes straight to writeback without starting the core
        send(3'b101, 32'h1234_5678, 32'h1, 5'd2);
        chk("ill_wb_valid", 32'(wb_valid), 32'h1);
        chk("ill_wb_data", wb_data, 32'h0);
        chk("ill_wb_flags", 32'(wb_flags), 32'h10);
        chk("ill_no_start", 32'(n_starts), 32'd1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("ill_fflags", 32'(fflags), 32'h10);
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        chk("clr_fflags", 32'(fflags), 32'h0);

        // flush coinciding with a request discards it
        flush = 1'b1;
        send(3'b000, 32'h1, 32'h2, 5'd4);
        flush = 1'b0;
        chk("flacc_busy", 32'(busy), 32'h0);
        chk("flacc_ready", 32'(req_ready), 32'h1);

        // div by zero, special path
        send(3'b011, 32'h3F80_0000, 32'h0, 5'd7);
        fp_valid = 1'b1; fp_result = 32'h7F80_0000; fp_flags = 5'b01000;
        step();
        fp_valid = 1'b0;
        chk("div_wb_valid", 32'(wb_valid), 32'h1);
        chk("div_wb_data", wb_data, 32'h7F80_0000);
        chk("div_wb_flags", 32'(wb_flags), 32'h08);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("div_fflags", 32'(fflags), 32'h08);

        // timeout after 64 WAIT cycles
        send(3'b010, 32'h4000_0000, 32'h4000_0000, 5'd3);
        step();
        for (int i = 0; i < 63; i++) step();
        chk("tmo_not_yet", 32'(wb_valid), 32'h0);
        chk("tmo_busy", 32'(busy), 32'h1);
        step();
        chk("tmo_err", 32'(timeout_err), 32'h1);
        chk("tmo_wb_valid", 32'(wb_valid), 32'h1);
        chk("tmo_wb_data", wb_data, 32'h7FC0_0000);
        chk("tmo_wb_flags", 32'(wb_flags), 32'h10);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("tmo_err_pulse", 32'(timeout_err), 32'h0);
        chk("tmo_fflags", 32'(fflags), 32'h18);

        // flush in WAIT, core answers two cycles later
        send(3'b000, 32'h3F80_0000, 32'h3F80_0000, 5'd9);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_drain_busy", 32'(busy), 32'h1);
        chk("fl_drain_wb", 32'(wb_valid), 32'h0);
        step();
        chk("fl_drain_start", 32'(fp_start), 32'h0);
        fp_valid = 1'b1; fp_result = 32'h4000_0000; fp_flags = 5'b00001;
        step();
        fp_valid = 1'b0;
        chk("fl_idle", 32'(busy), 32'h0);
        chk("fl_no_wb", 32'(wb_valid), 32'h0);
        chk("fl_fflags", 32'(fflags), 32'h18);

        // writeback back-pressure, then clear with handshake
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        send(3'b001, 32'h4000_0000, 32'h3F80_0000, 5'd12);
        fp_valid = 1'b1; fp_result = 32'h3F80_0000; fp_flags = 5'b00001;
        step();
        fp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_wb_valid", 32'(wb_valid), 32'h1);
            chk("bp_wb_data", wb_data, 32'h3F80_0000);
            chk("bp_wb_rd", 32'(wb_rd), 32'd12);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            step();
        end
        fflags_clr = 1'b1;
        wb_ready   = 1'b1;
        step();
        fflags_clr = 1'b0;
        wb_ready   = 1'b0;
        chk("bp_done", 32'(wb_valid), 32'h0);
        chk("bp_fflags", 32'(fflags), 32'h01);

        // flush in RESP drops writeback and keeps fflags
        send(3'b100, 32'h0, 32'h0, 5'd6);
        flush = 1'b1; wb_ready = 1'b1;
        step();
        flush = 1'b0; wb_ready = 1'b0;
        chk("flr_idle", 32'(wb_valid), 32'h0);
        chk("flr_fflags", 32'(fflags), 32'h01);

        // reset during WAIT, then a late core result
        send(3'b000, 32'h4040_0000, 32'h3F80_0000, 5'd20);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_fp_a", fp_a, 32'h0);
        chk("mrst_fflags", 32'(fflags), 32'h0);
        chk("mrst_wb_rd", 32'(wb_rd), 32'h0);
        step();
        rst = 1'b1;
        fp_valid = 1'b1; fp_result = 32'h4080_0000; fp_flags = 5'b00100;
        step();
        fp_valid = 1'b0;
        chk("late_no_wb", 32'(wb_valid), 32'h0);
        chk("late_busy", 32'(busy), 32'h0);
        send(3'b000, 32'h3F80_0000, 32'h3F80_0000, 5'd1);
        fp_valid = 1'b1; fp_result = 32'h4000_0000; fp_flags = 5'b0;
        step();
        fp_valid = 1'b0;
        chk("post_wb_valid", 32'(wb_valid), 32'h1);
        chk("post_wb_data", wb_data, 32'h4000_0000);
        chk("post_wb_rd", 32'(wb_rd), 32'd1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("post_idle", 32'(req_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
